// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared constants, width type and command-to-width mapping for the servo PWM generator
package servo_pkg;

    localparam int CENTER_US = 1500;
    localparam int MIN_US    = 1000;
    localparam int MAX_US    = 2000;
    localparam int SHIFT     = 6;

    typedef logic [10:0] width_t;

    // Map a signed command to a pulse width in microseconds, clamped to the servo's safe range.
    // The sum is kept at 17 bits signed so the full command range cannot overflow before clamping.
    function automatic width_t map_width(input logic [15:0] cmd);
        logic signed [16:0] ext;
        logic signed [16:0] sum;
        ext = {cmd[15], cmd};
        sum = 17'(CENTER_US) + (ext >>> SHIFT);
        if (sum < 17'(MIN_US)) begin
            return width_t'(MIN_US);
        end
        if (sum > 17'(MAX_US)) begin
            return width_t'(MAX_US);
        end
        return width_t'(sum);
    endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// rtl/servo_pwm_channel.sv - one servo channel: map/clamp, pending/active width and pulse comparator
module servo_pwm_channel
    import servo_pkg::*;
#(
    parameter int FW = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   cmd_i,
    input  logic          cmd_valid_i,
    input  logic          load_i,
    input  logic          force_center_i,
    input  logic [FW-1:0] frame_nxt_i,
    output logic          pwm_o
);

    width_t pend_q, pend_d;
    width_t act_q, act_d;
    logic   pwm_q, pwm_d;

    // Pending follows the latest command; active only changes on a frame boundary, so a pulse
    // already in flight never changes length. The comparator looks at next-cycle counter and
    // width so the output pin is a plain flop.
    always_comb begin
        pend_d = pend_q;
        act_d  = act_q;
        if (cmd_valid_i) begin
            pend_d = map_width(cmd_i);
        end else if (force_center_i) begin
            pend_d = width_t'(CENTER_US);
        end
        if (load_i) begin
            act_d = force_center_i ? width_t'(CENTER_US) : pend_q;
        end
        pwm_d = 32'(frame_nxt_i) < 32'(act_d);
    end

    // Width and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= width_t'(CENTER_US);
            act_q  <= width_t'(CENTER_US);
            pwm_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            act_q  <= act_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/servo_pwm_gen.sv
// rtl/servo_pwm_gen.sv - two-channel servo PWM generator with frame timing and command-loss failsafe
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int PERIOD_US       = 20000,
    parameter int FAILSAFE_FRAMES = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] roll_cmd,
    input  logic signed [15:0] pitch_cmd,
    input  logic               cmd_valid,
    output logic               pwm_roll,
    output logic               pwm_pitch,
    output logic               frame_start,
    output logic               failsafe
);

    localparam int DIV = CLK_HZ / 1_000_000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FW  = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
    localparam int MW  = $clog2(FAILSAFE_FRAMES + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(PERIOD_US - 1);
    localparam logic [MW-1:0] MISS_LAST  = MW'(FAILSAFE_FRAMES - 1);
    localparam logic [MW-1:0] MISS_MAX   = MW'(FAILSAFE_FRAMES);

    logic          run_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [MW-1:0] miss_q, miss_d;
    logic          seen_q, seen_d;
    logic          fs_q, fs_d;
    logic          fstart_q;
    logic          us_tick, frame_wrap, load, reach;

    // Timing and failsafe next-state. The first edge out of reset (run_q low) behaves like a
    // frame wrap so frame 0 begins with a frame_start pulse and a centred pulse, but it is not
    // counted as a missed frame.
    always_comb begin
        us_tick    = (presc_q == PRESC_LAST);
        frame_wrap = run_q && us_tick && (frame_q == FRAME_LAST);
        load       = !run_q || frame_wrap;

        presc_d = presc_q + PW'(1);
        if (!run_q || us_tick) begin
            presc_d = '0;
        end

        frame_d = frame_q;
        if (load) begin
            frame_d = '0;
        end else if (us_tick) begin
            frame_d = frame_q + FW'(1);
        end

        reach = frame_wrap && !cmd_valid && !seen_q && (miss_q >= MISS_LAST);

        miss_d = miss_q;
        if (cmd_valid) begin
            miss_d = '0;
        end else if (frame_wrap && !seen_q && (miss_q < MISS_MAX)) begin
            miss_d = miss_q + MW'(1);
        end

        seen_d = seen_q;
        if (load) begin
            seen_d = cmd_valid;
        end else if (cmd_valid) begin
            seen_d = 1'b1;
        end

        fs_d = fs_q;
        if (cmd_valid) begin
            fs_d = 1'b0;
        end else if (reach) begin
            fs_d = 1'b1;
        end
    end

    // Timing and failsafe state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q    <= 1'b0;
            presc_q  <= '0;
            frame_q  <= '0;
            miss_q   <= '0;
            seen_q   <= 1'b0;
            fs_q     <= 1'b0;
            fstart_q <= 1'b0;
        end else begin
            run_q    <= 1'b1;
            presc_q  <= presc_d;
            frame_q  <= frame_d;
            miss_q   <= miss_d;
            seen_q   <= seen_d;
            fs_q     <= fs_d;
            fstart_q <= load;
        end
    end

    servo_pwm_channel #(.FW(FW)) u_roll (
        .clk            (clk),
        .reset          (reset),
        .cmd_i          (roll_cmd),
        .cmd_valid_i    (cmd_valid),
        .load_i         (load),
        .force_center_i (reach),
        .frame_nxt_i    (frame_d),
        .pwm_o          (pwm_roll)
    );

    servo_pwm_channel #(.FW(FW)) u_pitch (
        .clk            (clk),
        .reset          (reset),
        .cmd_i          (pitch_cmd),
        .cmd_valid_i    (cmd_valid),
        .load_i         (load),
        .force_center_i (reach),
        .frame_nxt_i    (frame_d),
        .pwm_o          (pwm_pitch)
    );

    assign frame_start = fstart_q;
    assign failsafe    = fs_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb/tb_servo_pwm_gen.sv - self-checking bench for servo_pwm_gen against a frame-level reference model
module tb_servo_pwm_gen;

    localparam int CLK_HZ    = 2_000_000;
    localparam int PERIOD_US = 3000;
    localparam int FS        = 3;
    localparam int DIV       = CLK_HZ / 1_000_000;
    localparam int FRAME     = PERIOD_US * DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] roll_cmd;
    logic [15:0] pitch_cmd;
    logic        cmd_valid;
    logic        pwm_roll, pwm_pitch, frame_start, failsafe;

    servo_pwm_gen #(
        .CLK_HZ          (CLK_HZ),
        .PERIOD_US       (PERIOD_US),
        .FAILSAFE_FRAMES (FS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .roll_cmd    (roll_cmd),
        .pitch_cmd   (pitch_cmd),
        .cmd_valid   (cmd_valid),
        .pwm_roll    (pwm_roll),
        .pwm_pitch   (pwm_pitch),
        .frame_start (frame_start),
        .failsafe    (failsafe)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   found;
        int   wait_cyc;
        int   hi_r;
        int   hi_p;
        int   glitch;
        int   fs_bad;
        int   fst;
        logic fs0;
        logic fs_end;
    } frame_res_t;

    int tests = 0;
    int fails = 0;

    // Reference model state, in microseconds and whole frames.
    int   pend_r, pend_p, act_r, act_p, miss_m;
    logic fs_m, seen_m;

    // Strobes scheduled for the next frame: cycle offset within the frame and command values.
    int          s_n;
    int          s_off [2];
    logic [15:0] s_r [2];
    logic [15:0] s_p [2];

    function automatic int exp_width(input logic [15:0] cmd);
        int v, q, w;
        v = int'($signed(cmd));
        if (v >= 0) q = v / 64;
        else        q = -((-v + 63) / 64);
        w = 1500 + q;
        if (w < 1000) w = 1000;
        if (w > 2000) w = 2000;
        return w;
    endfunction

    task automatic model_reset();
        pend_r = 1500; pend_p = 1500; act_r = 1500; act_p = 1500;
        miss_m = 0; fs_m = 1'b0; seen_m = 1'b0; s_n = 0;
    endtask

    task automatic model_wrap();
        if (s_n > 0 && s_off[s_n-1] == FRAME - 1) begin
            act_r = pend_r; act_p = pend_p;
            pend_r = exp_width(s_r[s_n-1]); pend_p = exp_width(s_p[s_n-1]);
            miss_m = 0; fs_m = 1'b0; seen_m = 1'b1;
        end else begin
            if (!seen_m && miss_m < FS) miss_m++;
            if (!seen_m && miss_m == FS) begin
                fs_m = 1'b1; pend_r = 1500; pend_p = 1500;
            end
            act_r = pend_r; act_p = pend_p;
            seen_m = 1'b0;
        end
    endtask

    // Wait for a frame_start, then observe one frame while playing the scheduled strobes.
    // abort_at >= 0 asserts reset in that cycle and stops after one more edge.
    task automatic run_frame(input int abort_at, output frame_res_t r);
        r = '{default: 0};
        while (frame_start !== 1'b1 && r.wait_cyc < FRAME + 20) begin
            @(negedge clk);
            r.wait_cyc++;
        end
        if (frame_start !== 1'b1) return;
        r.found = 1;
        for (int c = 0; c < FRAME; c++) begin
            if (pwm_roll === 1'b1) begin
                if (c != r.hi_r) r.glitch++;
                r.hi_r++;
            end
            if (pwm_pitch === 1'b1) begin
                if (c != r.hi_p) r.glitch++;
                r.hi_p++;
            end
            if (c > 0 && frame_start !== 1'b0) r.fst++;
            if (failsafe !== fs_m) r.fs_bad++;
            if (c == 0) r.fs0 = failsafe;
            if (c == FRAME - 1) r.fs_end = failsafe;
            cmd_valid = 1'b0;
            for (int i = 0; i < s_n; i++) begin
                if (s_off[i] == c) begin
                    cmd_valid = 1'b1; roll_cmd = s_r[i]; pitch_cmd = s_p[i];
                    if (c != FRAME - 1) begin
                        pend_r = exp_width(s_r[i]); pend_p = exp_width(s_p[i]);
                        miss_m = 0; seen_m = 1'b1; fs_m = 1'b0;
                    end
                end
            end
            if (c == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                cmd_valid = 1'b0;
                s_n = 0;
                return;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        model_wrap();
        s_n = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; roll_cmd = '0; pitch_cmd = '0;
        repeat (4) @(negedge clk);
        tests++; if (pwm_roll !== 1'b0) begin fails++; $display("FAIL reset_pwm_roll: got %b, required 0", pwm_roll); end
        tests++; if (pwm_pitch !== 1'b0) begin fails++; $display("FAIL reset_pwm_pitch: got %b, required 0", pwm_pitch); end
        tests++; if (frame_start !== 1'b0) begin fails++; $display("FAIL reset_frame_start: got %b, required 0", frame_start); end
        tests++; if (failsafe !== 1'b0) begin fails++; $display("FAIL reset_failsafe: got %b, required 0", failsafe); end
        model_reset();
        reset = 1'b0;
    endtask

    task automatic test_idle();
        frame_res_t r;
        for (int f = 0; f < 2; f++) begin
            run_frame(-1, r);
            tests++; if (r.hi_r !== 1500 * DIV) begin fails++; $display("FAIL idle_roll f%0d: high %0d cycles, required %0d", f, r.hi_r, 1500 * DIV); end
            tests++; if (r.hi_p !== 1500 * DIV) begin fails++; $display("FAIL idle_pitch f%0d: high %0d cycles, required %0d", f, r.hi_p, 1500 * DIV); end
            tests++; if (r.glitch + r.fs_bad + r.fst !== 0) begin fails++; $display("FAIL idle_integrity f%0d: glitch=%0d fs_err=%0d extra_fstart=%0d, required 0", f, r.glitch, r.fs_bad, r.fst); end
            tests++; if (r.wait_cyc > (f == 0 ? 2 : 0)) begin fails++; $display("FAIL idle_frame_start_spacing f%0d: waited %0d extra cycles, required <= %0d", f, r.wait_cyc, f == 0 ? 2 : 0); end
        end
    endtask

    task automatic test_mid_frame_cmd();
        frame_res_t r;
        s_n = 1; s_off[0] = 4000; s_r[0] = 16'h7FFF; s_p[0] = 16'h8000;
        run_frame(-1, r);
        tests++; if (r.hi_r !== 1500 * DIV) begin fails++; $display("FAIL midcmd_roll_same_frame: high %0d, required %0d", r.hi_r, 1500 * DIV); end
        tests++; if (r.hi_p !== 1500 * DIV) begin fails++; $display("FAIL midcmd_pitch_same_frame: high %0d, required %0d", r.hi_p, 1500 * DIV); end
        tests++; if (r.glitch + r.fs_bad + r.fst !== 0) begin fails++; $display("FAIL midcmd_integrity: glitch=%0d fs_err=%0d extra_fstart=%0d, required 0", r.glitch, r.fs_bad, r.fst); end
    endtask

    task automatic test_wrap_edge_cmd();
        frame_res_t r;
        int ep;
        s_n = 1; s_off[0] = FRAME - 1; s_r[0] = 16'h0C80; s_p[0] = 16'($urandom);
        run_frame(-1, r);
        tests++; if (r.hi_r !== 2000 * DIV) begin fails++; $display("FAIL wrapcmd_roll_clamp_max: high %0d, required %0d", r.hi_r, 2000 * DIV); end
        tests++; if (r.hi_p !== 1000 * DIV) begin fails++; $display("FAIL wrapcmd_pitch_clamp_min: high %0d, required %0d", r.hi_p, 1000 * DIV); end
        tests++; if (r.glitch + r.fs_bad + r.fst !== 0) begin fails++; $display("FAIL wrapcmd_integrity_a: glitch=%0d fs_err=%0d extra_fstart=%0d, required 0", r.glitch, r.fs_bad, r.fst); end
        run_frame(-1, r);
        tests++; if (r.hi_r !== 2000 * DIV) begin fails++; $display("FAIL wrapcmd_roll_old_width: high %0d, required %0d", r.hi_r, 2000 * DIV); end
        tests++; if (r.hi_p !== 1000 * DIV) begin fails++; $display("FAIL wrapcmd_pitch_old_width: high %0d, required %0d", r.hi_p, 1000 * DIV); end
        ep = act_p * DIV;
        s_n = 0;
        run_frame(-1, r);
        tests++; if (r.hi_r !== 1550 * DIV) begin fails++; $display("FAIL wrapcmd_roll_new_width: high %0d, required %0d", r.hi_r, 1550 * DIV); end
        tests++; if (r.hi_p !== ep) begin fails++; $display("FAIL wrapcmd_pitch_new_width: high %0d, required %0d", r.hi_p, ep); end
    endtask

    task automatic test_last_strobe_wins();
        frame_res_t r;
        int ep;
        s_n = 2;
        s_off[0] = $urandom_range(1, 2999);    s_r[0] = 16'h0000; s_p[0] = 16'($urandom);
        s_off[1] = $urandom_range(3000, 5990); s_r[1] = 16'h1900; s_p[1] = 16'($urandom);
        ep = act_p * DIV;
        run_frame(-1, r);
        tests++; if (r.hi_p !== ep) begin fails++; $display("FAIL twostrobe_pitch_current: high %0d, required %0d", r.hi_p, ep); end
        tests++; if (r.glitch + r.fs_bad + r.fst !== 0) begin fails++; $display("FAIL twostrobe_integrity: glitch=%0d fs_err=%0d extra_fstart=%0d, required 0", r.glitch, r.fs_bad, r.fst); end
        ep = act_p * DIV;
        s_n = 1; s_off[0] = $urandom_range(0, 5990); s_r[0] = 16'h7FFF; s_p[0] = 16'($urandom);
        run_frame(-1, r);
        tests++; if (r.hi_r !== 1600 * DIV) begin fails++; $display("FAIL twostrobe_roll_last_wins: high %0d, required %0d", r.hi_r, 1600 * DIV); end
        tests++; if (r.hi_p !== ep) begin fails++; $display("FAIL twostrobe_pitch_last_wins: high %0d, required %0d", r.hi_p, ep); end
    endtask

    task automatic test_failsafe();
        frame_res_t r;
        int ep;
        for (int f = 0; f < FS; f++) begin
            ep = act_p * DIV;
            run_frame(-1, r);
            tests++; if (r.hi_r !== 2000 * DIV || r.hi_p !== ep) begin fails++; $display("FAIL failsafe_hold f%0d: roll %0d pitch %0d, required %0d and %0d", f, r.hi_r, r.hi_p, 2000 * DIV, ep); end
            tests++; if (r.fs0 !== 1'b0 || r.fs_bad !== 0) begin fails++; $display("FAIL failsafe_early f%0d: failsafe=%b errs=%0d, required 0 and 0", f, r.fs0, r.fs_bad); end
        end
        s_n = 1; s_off[0] = 2500; s_r[0] = 16'h7FFF; s_p[0] = 16'($urandom);
        run_frame(-1, r);
        tests++; if (r.fs0 !== 1'b1) begin fails++; $display("FAIL failsafe_rise: got %b, required 1", r.fs0); end
        tests++; if (r.hi_r !== 1500 * DIV || r.hi_p !== 1500 * DIV) begin fails++; $display("FAIL failsafe_centre: roll %0d pitch %0d, required %0d", r.hi_r, r.hi_p, 1500 * DIV); end
        tests++; if (r.fs_end !== 1'b0 || r.fs_bad !== 0) begin fails++; $display("FAIL failsafe_clear: end=%b errs=%0d, required 0 and 0", r.fs_end, r.fs_bad); end
    endtask

    task automatic test_reset_mid_pulse();
        frame_res_t r;
        run_frame(1000, r);
        tests++; if (r.hi_r !== 1001 || r.hi_p !== 1001) begin fails++; $display("FAIL midreset_before: roll %0d pitch %0d high cycles, required 1001", r.hi_r, r.hi_p); end
        tests++; if (pwm_roll !== 1'b0 || pwm_pitch !== 1'b0) begin fails++; $display("FAIL midreset_pwm_low: roll %b pitch %b, required 0 0", pwm_roll, pwm_pitch); end
        tests++; if (frame_start !== 1'b0 || failsafe !== 1'b0) begin fails++; $display("FAIL midreset_flags: frame_start %b failsafe %b, required 0 0", frame_start, failsafe); end
        repeat (2) @(negedge clk);
        model_reset();
        reset = 1'b0;
        run_frame(-1, r);
        tests++; if (r.wait_cyc > 2 || r.found !== 1) begin fails++; $display("FAIL midreset_restart: waited %0d found %0d, required <=2 and 1", r.wait_cyc, r.found); end
        tests++; if (r.hi_r !== 1500 * DIV || r.hi_p !== 1500 * DIV) begin fails++; $display("FAIL midreset_clean_frame: roll %0d pitch %0d, required %0d", r.hi_r, r.hi_p, 1500 * DIV); end
        tests++; if (r.glitch + r.fs_bad + r.fst !== 0) begin fails++; $display("FAIL midreset_integrity: glitch=%0d fs_err=%0d extra_fstart=%0d, required 0", r.glitch, r.fs_bad, r.fst); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_idle();
        test_mid_frame_cmd();
        test_wrap_edge_cmd();
        test_last_strobe_wins();
        test_failsafe();
        test_reset_mid_pulse();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
